// File: rtl/vdp_sprite_pkg.sv
// Shared layout for the sprite hit scanner: hit-entry field offsets,
// height-select encoding, terminator bit and scan FSM states.
package vdp_sprite_pkg;

  localparam int HIT_TERM_BIT   = 15;
  localparam int HIT_WSEL_BIT   = 14;
  localparam int HIT_OFFSET_LSB = 8;
  localparam int HIT_ID_LSB     = 0;
  localparam int OFFSET_W       = 5;
  localparam int ID_W           = 8;

  typedef enum logic [1:0] {
    HSEL_8      = 2'd0,
    HSEL_16     = 2'd1,
    HSEL_32     = 2'd2,
    HSEL_32_ALT = 2'd3
  } hsel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_TERM  = 2'd3
  } scan_state_e;

  function automatic logic [5:0] height_of(input hsel_e hsel);
    case (hsel)
      HSEL_8:  height_of = 6'd8;
      HSEL_16: height_of = 6'd16;
      default: height_of = 6'd32;
    endcase
  endfunction

  function automatic logic [15:0] hit_entry(input logic term, input logic wsel,
                                            input logic [OFFSET_W-1:0] offset,
                                            input logic [ID_W-1:0] id);
    logic [15:0] e;
    e = 16'd0;
    e[HIT_TERM_BIT] = term;
    e[HIT_WSEL_BIT] = wsel;
    e[HIT_OFFSET_LSB +: OFFSET_W] = offset;
    e[HIT_ID_LSB +: ID_W] = id;
    return e;
  endfunction

endpackage

// File: rtl/vdp_sprite_y_test.sv
// Combinational vertical intersection test for one sprite y-block word:
// wrapped row delta, height compare and (optionally flipped) line offset.
module vdp_sprite_y_test
  import vdp_sprite_pkg::*;
#(
  parameter int Y_WIDTH = 9
) (
  input  logic [Y_WIDTH-1:0]  i_raster_y,
  input  logic [15:0]         i_sprite_y_data,
  output logic                o_hit,
  output logic                o_width_sel,
  output logic [OFFSET_W-1:0] o_line_offset
);

  localparam int CW = (Y_WIDTH > 6) ? Y_WIDTH : 6;

  logic [Y_WIDTH-1:0] w_sprite_y;
  logic [Y_WIDTH-1:0] w_delta;
  logic [CW-1:0]      w_delta_ext;
  logic [CW-1:0]      w_height_ext;
  logic [5:0]         w_height;
  logic               w_flip_y;
  logic               w_unused_bits;

  assign w_sprite_y    = i_sprite_y_data[Y_WIDTH-1:0];
  assign o_width_sel   = i_sprite_y_data[Y_WIDTH];
  assign w_flip_y      = i_sprite_y_data[Y_WIDTH+1];
  assign w_height      = height_of(hsel_e'(i_sprite_y_data[Y_WIDTH+3:Y_WIDTH+2]));
  assign w_unused_bits = ^(i_sprite_y_data >> (Y_WIDTH + 4));

  // Subtraction wraps modulo 2^Y_WIDTH, so sprites straddling the top edge still hit.
  assign w_delta      = i_raster_y - w_sprite_y;
  assign w_delta_ext  = CW'(w_delta);
  assign w_height_ext = CW'(w_height);
  assign o_hit        = (w_delta_ext < w_height_ext);

  // Row within the sprite, mirrored when flip_y is set.
  always_comb begin
    if (w_flip_y) begin
      o_line_offset = w_height[4:0] - 5'd1 - w_delta_ext[4:0];
    end else begin
      o_line_offset = w_delta_ext[4:0];
    end
  end

endmodule

// File: rtl/vdp_sprite_hit_scanner.sv
// Per-line sprite scanner: reads every y-block entry, writes intersecting sprites to
// the hit list, then a terminator. VDP_SPRITE_OVERFLOW_COUNT_EN adds dropped_count
// and forces a full scan; otherwise the scan stops as soon as the list is full.
module vdp_sprite_hit_scanner
  import vdp_sprite_pkg::*;
#(
  parameter int SPRITE_COUNT = 256,
  parameter int MAX_PER_LINE = 32,
  parameter int Y_WIDTH      = 9
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [Y_WIDTH-1:0]              i_raster_y,
  output logic [$clog2(SPRITE_COUNT)-1:0] o_sprite_read_address,
  input  logic [15:0]                     i_sprite_y_data,
  output logic                            o_hit_write_en,
  output logic [7:0]                      o_hit_write_address,
  output logic [15:0]                     o_hit_write_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [7:0]                      o_hit_count,
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
  output logic [9:0]                      o_dropped_count,
`endif
  output logic                            o_overflow
);

  localparam int AW = $clog2(SPRITE_COUNT);

  scan_state_e        r_state;
  logic               r_drain_cnt;
  logic [Y_WIDTH-1:0] r_raster_y;
  logic [AW-1:0]      r_rd_addr;
  logic [AW-1:0]      r_rd_idx;
  logic               r_rd_valid;
  logic               r_we;
  logic [7:0]         r_wa;
  logic [15:0]        r_wd;
  logic               r_busy;
  logic               r_done;
  logic [7:0]         r_hit_count;
  logic               r_overflow;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
  logic [9:0]         r_dropped;
`endif

  logic               w_hit;
  logic               w_wsel;
  logic [OFFSET_W-1:0] w_offset;
  logic               w_full;
  logic               w_last_addr;
  logic               w_accept;
  logic               w_reject;
  logic               w_end_scan;

  vdp_sprite_y_test #(.Y_WIDTH(Y_WIDTH)) u_y_test (
    .i_raster_y      (r_raster_y),
    .i_sprite_y_data (i_sprite_y_data),
    .o_hit           (w_hit),
    .o_width_sel     (w_wsel),
    .o_line_offset   (w_offset)
  );

  assign w_full      = (r_hit_count == 8'(MAX_PER_LINE));
  assign w_last_addr = (r_rd_addr == AW'(SPRITE_COUNT - 1));
  assign w_accept    = r_rd_valid && w_hit && !w_full;
  assign w_reject    = r_rd_valid && w_hit && w_full;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
  assign w_end_scan  = w_last_addr;
`else
  assign w_end_scan  = w_last_addr ||
                       (w_accept && (r_hit_count == 8'(MAX_PER_LINE - 1)));
`endif

  // Scan FSM, read pipeline and hit-list write port; start restarts from any state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 1'b0;
      r_raster_y  <= '0;
      r_rd_addr   <= '0;
      r_rd_idx    <= '0;
      r_rd_valid  <= 1'b0;
      r_we        <= 1'b0;
      r_wa        <= 8'd0;
      r_wd        <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_hit_count <= 8'd0;
      r_overflow  <= 1'b0;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
      r_dropped   <= 10'd0;
`endif
    end else if (i_start) begin
      r_state     <= ST_SCAN;
      r_drain_cnt <= 1'b0;
      r_raster_y  <= i_raster_y;
      r_rd_addr   <= '0;
      r_rd_idx    <= '0;
      r_rd_valid  <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_hit_count <= 8'd0;
      r_overflow  <= 1'b0;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
      r_dropped   <= 10'd0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_rd_valid <= (r_state == ST_SCAN);
      r_rd_idx   <= r_rd_addr;

      // The pipeline is always empty by the second drain cycle, so the terminator never collides with a hit.
      if ((r_state == ST_DRAIN) && r_drain_cnt) begin
        r_we <= 1'b1;
        r_wa <= r_hit_count;
        r_wd <= hit_entry(1'b1, 1'b0, 5'd0, 8'd0);
      end else if (w_accept) begin
        r_we        <= 1'b1;
        r_wa        <= r_hit_count;
        r_wd        <= hit_entry(1'b0, w_wsel, w_offset, 8'(r_rd_idx));
        r_hit_count <= r_hit_count + 8'd1;
      end else if (w_reject) begin
        r_overflow <= 1'b1;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
        if (r_dropped != 10'd1023) begin
          r_dropped <= r_dropped + 10'd1;
        end
`endif
      end

      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
        end
        ST_SCAN: begin
          if (!w_last_addr) begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
          if (w_end_scan) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt) begin
            r_state <= ST_TERM;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        ST_TERM: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sprite_read_address = r_rd_addr;
  assign o_hit_write_en        = r_we;
  assign o_hit_write_address   = r_wa;
  assign o_hit_write_data      = r_wd;
  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_hit_count           = r_hit_count;
  assign o_overflow            = r_overflow;
`ifdef VDP_SPRITE_OVERFLOW_COUNT_EN
  assign o_dropped_count       = r_dropped;
`endif

endmodule
